// File: rtl/reg_file_block_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : reg_file_block_pkg
// Brief  : Shared sizes, reset values and named addresses for reg_file_block.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package reg_file_block_pkg;

  localparam int RF_WIDTH  = 8;
  localparam int RF_DEPTH  = 16;
  localparam int RF_ADDR_W = 4;

  // UART config: parity enabled, even parity, prescale 32
  localparam logic [7:0] REG2_RST = 8'h81;
  localparam logic [7:0] REG3_RST = 8'h20;

  localparam logic [3:0] ADDR_REG0 = 4'd0;
  localparam logic [3:0] ADDR_REG1 = 4'd1;
  localparam logic [3:0] ADDR_REG2 = 4'd2;
  localparam logic [3:0] ADDR_REG3 = 4'd3;

endpackage : reg_file_block_pkg
`default_nettype wire

// File: rtl/reg_file_block_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : reg_file_block_if
// Brief  : Access bus and configuration taps of the register file.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
interface reg_file_block_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);

  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Address;
  logic [WIDTH-1:0]  WrData;
  logic [WIDTH-1:0]  RdData;
  logic              RdData_Valid;
  logic [WIDTH-1:0]  REG0;
  logic [WIDTH-1:0]  REG1;
  logic [WIDTH-1:0]  REG2;
  logic [WIDTH-1:0]  REG3;

  modport master (
    output WrEn, RdEn, Address, WrData,
    input  RdData, RdData_Valid, REG0, REG1, REG2, REG3
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData,
    output RdData, RdData_Valid, REG0, REG1, REG2, REG3
  );

endinterface : reg_file_block_if
`default_nettype wire

// File: rtl/reg_file_block.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : reg_file_block
// Brief  : 16x8 register file, registered read with valid strobe, entries 0-3
//          tapped out as live configuration outputs.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module reg_file_block
  import reg_file_block_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  wire logic         clk,
  input  wire logic         RST,
  reg_file_block_if.slave   rf
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_wr;
  logic             w_rd;

  // Both enables together is an illegal request and is dropped entirely
  assign w_wr = rf.WrEn & ~rf.RdEn;
  assign w_rd = rf.RdEn & ~rf.WrEn;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_mem[ADDR_REG2] <= WIDTH'(REG2_RST);
      r_mem[ADDR_REG3] <= WIDTH'(REG3_RST);
    end else if (w_wr) begin
      r_mem[rf.Address] <= rf.WrData;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= r_mem[rf.Address];
      end
    end
  end

  assign rf.RdData       = r_rd_data;
  assign rf.RdData_Valid = r_rd_valid;

  assign rf.REG0 = r_mem[ADDR_REG0];
  assign rf.REG1 = r_mem[ADDR_REG1];
  assign rf.REG2 = r_mem[ADDR_REG2];
  assign rf.REG3 = r_mem[ADDR_REG3];

endmodule : reg_file_block
`default_nettype wire

// File: tb/tb_reg_file_block.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_reg_file_block
// Brief  : Directed scoreboard bench for reg_file_block.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_reg_file_block;

  logic clk;
  logic RST;
  int   n_total;
  int   n_pass;
  logic [7:0] sb_q [$];

  reg_file_block_if #(.WIDTH(8), .ADDR_W(4)) rf ();

  reg_file_block dut (
    .clk (clk),
    .RST (RST),
    .rf  (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
  endtask

  // Read data is checked whenever the DUT flags it valid
  always @(negedge clk) begin
    if (!RST && rf.RdData_Valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_valid: got RdData 0x%02h expected no valid at %0t", rf.RdData, $time);
      end else begin
        chk("rd_data", rf.RdData, sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    rf.Address = a;
    rf.WrData  = d;
    rf.RdEn    = 1'b0;
    rf.WrEn    = 1'b1;
    step();
    rf.WrEn    = 1'b0;
  endtask

  // Leaves RdEn high so back-to-back calls read every cycle
  task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
    rf.Address = a;
    rf.WrEn    = 1'b0;
    rf.RdEn    = 1'b1;
    sb_q.push_back(exp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total    = 0;
    n_pass     = 0;
    RST        = 1'b1;
    rf.WrEn    = 1'b0;
    rf.RdEn    = 1'b0;
    rf.Address = '0;
    rf.WrData  = '0;

    // 1: reset state
    step();
    step();
    RST = 1'b0;
    step();
    chk("rst_reg0", rf.REG0, 8'h00);
    chk("rst_reg1", rf.REG1, 8'h00);
    chk("rst_reg2", rf.REG2, 8'h81);
    chk("rst_reg3", rf.REG3, 8'h20);
    chk("rst_rddata", rf.RdData, 8'h00);
    chk("rst_valid", {7'd0, rf.RdData_Valid}, 8'h00);

    // 2: write then read back, valid drops after RdEn falls
    do_write(4'd5, 8'h05);
    chk("wr_valid_low", {7'd0, rf.RdData_Valid}, 8'h00);
    do_read(4'd5, 8'h05);
    chk("rd_valid_high", {7'd0, rf.RdData_Valid}, 8'h01);
    rf.RdEn = 1'b0;
    step();
    chk("valid_drop", {7'd0, rf.RdData_Valid}, 8'h00);
    chk("rd_hold", rf.RdData, 8'h05);

    // 3: continuous reads across several addresses
    do_write(4'd11, 8'h07);
    do_read(4'd11, 8'h07);
    do_read(4'd10, 8'h00);
    do_read(4'd3,  8'h20);
    do_read(4'd0,  8'h00);
    chk("rd_burst_valid", {7'd0, rf.RdData_Valid}, 8'h01);
    rf.RdEn = 1'b0;
    step();

    // 4: config tap updates right after the write edge
    do_write(4'd1, 8'hA5);
    chk("reg1_tap", rf.REG1, 8'hA5);
    chk("wr_valid_low2", {7'd0, rf.RdData_Valid}, 8'h00);
    chk("wr_rd_hold", rf.RdData, 8'h00);

    // 5: simultaneous enables are dropped
    rf.Address = 4'd2;
    rf.WrData  = 8'hFF;
    rf.WrEn    = 1'b1;
    rf.RdEn    = 1'b1;
    step();
    rf.WrEn = 1'b0;
    rf.RdEn = 1'b0;
    chk("both_reg2", rf.REG2, 8'h81);
    chk("both_valid", {7'd0, rf.RdData_Valid}, 8'h00);
    chk("both_rd_hold", rf.RdData, 8'h00);
    do_read(4'd2, 8'h81);
    rf.RdEn = 1'b0;
    step();

    // 6: async reset between edges
    do_write(4'd0, 8'h33);
    chk("reg0_tap", rf.REG0, 8'h33);
    do_read(4'd0, 8'h33);
    rf.RdEn = 1'b0;
    @(negedge clk);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_reg0", rf.REG0, 8'h00);
    chk("arst_reg1", rf.REG1, 8'h00);
    chk("arst_reg2", rf.REG2, 8'h81);
    chk("arst_rddata", rf.RdData, 8'h00);
    chk("arst_valid", {7'd0, rf.RdData_Valid}, 8'h00);
    #1;
    RST = 1'b0;
    step();

    // Operations after reset release are honoured
    do_write(4'd15, 8'h5A);
    do_read(4'd15, 8'h5A);
    rf.RdEn = 1'b0;
    step();
    step();

    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d pending reads expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_file_block
`default_nettype wire
